// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding, the frame data width and the default
// baud counts used by the receiver and its sibling baud-tick/TX blocks.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // Default baud configuration: 115200 baud from a 125 MHz clock.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1085;
  localparam int unsigned DEFAULT_SYNC_STAGES  = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage : uart_rx_pkg

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i - sampling clock
//   rst_i - synchronous reset, active-high; loads RST_VAL into every stage
//   d_i   - asynchronous input
//   q_o   - synchronized output (last stage)
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; stage 0 is the only flop that sees the async input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a one-byte holding register.
// Phase-aligns its own bit counter to the start-bit falling edge and samples
// every bit at mid-period. Flags framing and overrun errors as 1-cycle pulses.
// Ports:
//   clk         - system clock
//   rst         - synchronous reset, active-high
//   rx          - asynchronous serial line, idle high
//   rx_data     - last received byte
//   rx_valid    - rx_data holds an unconsumed byte
//   rx_ready    - consumer takes rx_data when rx_valid && rx_ready
//   frame_err   - pulse: stop bit sampled low
//   overrun_err - pulse: byte completed while previous byte still pending
//   busy        - receiver is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ferr_q, ferr_d;
  logic                        oerr_q, oerr_d;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          idx_d = '0;
          // A line back high at mid start bit was a glitch, not a frame.
          state_d = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // A same-edge consume frees the slot, so that is not an overrun.
            oerr_d  = valid_q & ~rx_ready;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 16, SYNC_STAGES = 2.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   rise_cyc = -1;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Hold the line at v for n cycles; called and returns at a negedge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Monitor: every observable DUT event pops one expectation.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    int   kind;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        kind = -1;
        if (frame_err) kind = K_FERR;
        else if (overrun_err) kind = K_OVR;
        else if (rx_valid && !prev_valid) kind = K_BYTE;
        if (kind == K_BYTE) rise_cyc = cyc;
        if (kind >= 0) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data 0x%02h, expected none", kind, rx_data);
          end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind != K_FERR) check("event_data", int'(rx_data), int'(e.data));
          end
        end
        prev_valid = rx_valid;
      end
    end
  end

  initial begin : stim
    int c0;
    int lat;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", int'(rx_data), 8'h00);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_oerr", int'(overrun_err), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    hold(1'b1, 10);

    // Byte 0xA5, consumer not ready; latency from line fall to rx_valid.
    push(K_BYTE, 8'hA5);
    c0 = cyc;
    send(8'hA5, 1'b1);
    hold(1'b1, 20);
    check("a5_pending", sb.size(), 0);
    lat = rise_cyc - c0;
    check("a5_latency_in_154_156", int'(lat >= 154 && lat <= 156), 1);
    check("a5_data", int'(rx_data), 8'hA5);
    check("a5_valid", int'(rx_valid), 1);
    consume();
    check("a5_valid_cleared", int'(rx_valid), 0);

    // Short low glitch: brief busy, then idle, no events.
    hold(1'b0, 4);
    check("glitch_busy", int'(busy), 1);
    hold(1'b1, 12);
    check("glitch_idle", int'(busy), 0);
    check("glitch_no_valid", int'(rx_valid), 0);

    // Framing error on 0x3C: old data kept, no valid.
    push(K_FERR, 8'h00);
    send(8'h3C, 1'b0);
    hold(1'b1, 40);
    check("ferr_pending", sb.size(), 0);
    check("ferr_valid", int'(rx_valid), 0);
    check("ferr_data_kept", int'(rx_data), 8'hA5);

    // Back-to-back frames with the consumer always ready.
    rx_ready = 1'b1;
    push(K_BYTE, 8'h01);
    push(K_BYTE, 8'hFE);
    send(8'h01, 1'b1);
    send(8'hFE, 1'b1);
    hold(1'b1, 20);
    rx_ready = 1'b0;
    check("b2b_pending", sb.size(), 0);
    check("b2b_valid", int'(rx_valid), 0);
    check("b2b_data", int'(rx_data), 8'hFE);

    // Overrun: second byte lands while the first is still pending.
    push(K_BYTE, 8'h55);
    push(K_OVR, 8'hAA);
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    hold(1'b1, 20);
    check("ovr_pending", sb.size(), 0);
    check("ovr_data", int'(rx_data), 8'hAA);
    check("ovr_valid", int'(rx_valid), 1);
    consume();
    check("ovr_valid_cleared", int'(rx_valid), 0);

    // Reset during bit 4 of 0x81, then a clean 0x81.
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, CPB);
    hold(1'b0, CPB / 2);
    check("midframe_busy", int'(busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_data", int'(rx_data), 8'h00);
    check("rst_mid_valid", int'(rx_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ferr", int'(frame_err), 0);
    hold(1'b1, 20);
    check("rst_mid_quiet", int'(busy), 0);
    push(K_BYTE, 8'h81);
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    check("post_rst_pending", sb.size(), 0);
    check("post_rst_data", int'(rx_data), 8'h81);
    check("post_rst_valid", int'(rx_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx
